hs_fir_interp2: RTL and testbench

Half-band FIR interpolator-by-2: the upsampling counterpart of the team's half-band FIR decimation path. It accepts 8-bit signed samples at rate Fs and emits 8-bit signed samples at 2·Fs using a 7-tap half-band kernel [-1, 0, 9, 16, 9, 0, -1]/16, evaluated polyphase with shift-add only, no multipliers. Both sides use valid/ready handshakes, so the block can sit between a sample source and any back-pressuring sink in the DSP chain.

---
 rtl/hs_fir_interp2.sv | 118 +++++++++++
 tb/tb_hs_fir_interp2.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/hs_fir_interp2.sv
// Half-band FIR interpolator-by-2, kernel [-1,0,9,16,9,0,-1]/16, polyphase shift-add.
// Define HS_FIR_INTERP2_SAT_EN to clamp the interpolated (mid) sample instead of wrapping it.
module hs_fir_interp2 (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic signed [7:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic signed [7:0] o_data,
  output logic              o_valid,
  input  logic              i_ready
);

  localparam int DATA_W = 8;
  localparam int ACC_W  = 14;

  typedef enum logic [1:0] {S_ACCEPT, S_OUT0, S_OUT1} state_t;

  state_t state, state_nx;
  logic   accept, load_mid, drop_valid;

  // x[n-1], x[n-2] and x[n-3] are d0..d2 before the shift; x[n-3] is never needed afterwards.
  logic signed [DATA_W-1:0] d0, d1, d2;
  logic signed [DATA_W-1:0] mid_r;

  logic signed [ACC_W-1:0] near_p0, far_p0, sum_p0;
  logic signed [DATA_W-1:0] mid_p0;

  function automatic logic signed [ACC_W-1:0] round_shr4(input logic signed [ACC_W-1:0] v);
    return (v + 14'sd8) >>> 4;
  endfunction

  function automatic logic signed [DATA_W-1:0] fit_out(input logic signed [ACC_W-1:0] v);
`ifdef HS_FIR_INTERP2_SAT_EN
    if (v > 14'sd127)
      return 8'sd127;
    else if (v < -14'sd128)
      return -8'sd128;
    else
      return v[DATA_W-1:0];
`else
    return v[DATA_W-1:0];
`endif
  endfunction

  // Stage p0: odd-phase tap sum from the incoming sample and the pre-shift delay line
  always_comb begin
    near_p0 = ACC_W'(d1) + ACC_W'(d0);
    far_p0  = ACC_W'(d2) + ACC_W'(i_data);
    sum_p0  = (near_p0 <<< 3) + near_p0 - far_p0;
    mid_p0  = fit_out(round_shr4(sum_p0));
  end

  always_comb begin
    state_nx   = state;
    o_ready    = 1'b0;
    accept     = 1'b0;
    load_mid   = 1'b0;
    drop_valid = 1'b0;
    case (state)
      S_ACCEPT: begin
        o_ready = 1'b1;
        if (i_valid) begin
          accept   = 1'b1;
          state_nx = S_OUT0;
        end
      end
      S_OUT0: begin
        if (i_ready) begin
          load_mid = 1'b1;
          state_nx = S_OUT1;
        end
      end
      S_OUT1: begin
        // Handing off mid and taking the next sample on one edge keeps the stream bubble-free.
        o_ready = i_ready;
        if (i_ready) begin
          if (i_valid) begin
            accept   = 1'b1;
            state_nx = S_OUT0;
          end else begin
            drop_valid = 1'b1;
            state_nx   = S_ACCEPT;
          end
        end
      end
      default: state_nx = S_ACCEPT;
    endcase
  end

  // Stage p1: registered outputs and delay line
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state   <= S_ACCEPT;
      d0      <= '0;
      d1      <= '0;
      d2      <= '0;
      mid_r   <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        d0      <= i_data;
        d1      <= d0;
        d2      <= d1;
        mid_r   <= mid_p0;
        o_data  <= d1;
        o_valid <= 1'b1;
      end else if (load_mid) begin
        o_data <= mid_r;
      end else if (drop_valid) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hs_fir_interp2.sv
// Scoreboard bench for hs_fir_interp2: a driver pushes model outputs per accepted sample,
// a monitor pops and compares on every output handshake.
module tb_hs_fir_interp2;

  logic              i_clk;
  logic              i_reset;
  logic signed [7:0] i_data;
  logic              i_valid;
  logic              o_ready;
  logic signed [7:0] o_data;
  logic              o_valid;
  logic              i_ready;

  hs_fir_interp2 dut (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_data (i_data),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .o_data (o_data),
    .o_valid(o_valid),
    .i_ready(i_ready)
  );

  int sb[$];
  int obs[$];
  int hist[3];   // x[n-1], x[n-2], x[n-3]
  int errors = 0;
  int checks = 0;
  bit stall_prev = 1'b0;
  int prev_data = 0;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: the two output samples of a half-band interpolator for input x[n].
  function automatic int fit8(input int v);
`ifdef HS_FIR_INTERP2_SAT_EN
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
`else
    return ((v + 128 + 1024) % 256) - 128;
`endif
  endfunction

  function automatic void model_push(input int x);
    int raw, rnd;
    raw = 9 * (hist[1] + hist[0]) - (hist[2] + x);
    rnd = (raw + 8 + 4096) / 16 - 256;   // floor((raw+8)/16)
    sb.push_back(hist[1]);
    sb.push_back(fit8(rnd));
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = x;
  endfunction

  task automatic step(input bit v, input int d, input bit r, output bit acc);
    int q;
    @(posedge i_clk);
    #1;
    i_valid = v;
    i_data  = d[7:0];
    i_ready = r;
    @(negedge i_clk);
    q = sb.size();
    chk("o_valid", int'(o_valid), (q != 0) ? 1 : 0);
    chk("o_ready", int'(o_ready), (q == 0) ? 1 : ((q == 1) ? int'(r) : 0));
    acc = v && o_ready;
    if (acc) model_push(int'($signed(d[7:0])));
  endtask

  task automatic send(input int x, input bit rnd_ready);
    bit acc;
    acc = 1'b0;
    for (int k = 0; k < 64 && !acc; k++)
      step(1'b1, x, rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1, acc);
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    bit acc;
    for (int k = 0; k < 64 && sb.size() != 0; k++)
      step(1'b0, 0, 1'b1, acc);
    step(1'b0, 0, 1'b1, acc);
    chk("drain_left", sb.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    sb.delete();
    hist = '{0, 0, 0};
    @(negedge i_clk);
    chk("rst_hold_valid", int'(o_valid), 0);
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    @(negedge i_clk);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_data", int'($signed(o_data)), 0);
    chk("rst_ready", int'(o_ready), 1);
    obs.delete();
  endtask

  // Monitor: one transfer per cycle where o_valid && i_ready at the coming edge.
  initial begin
    int exp;
    forever begin
      @(negedge i_clk);
      #1;
      if (i_reset) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("stall_data", int'($signed(o_data)), prev_data);
          chk("stall_valid", int'(o_valid), 1);
        end
        if (o_valid && i_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_extra: got %0d expected no output", $signed(o_data));
          end else begin
            exp = sb.pop_front();
            chk("out", int'($signed(o_data)), exp);
          end
          obs.push_back(int'($signed(o_data)));
        end
        stall_prev = o_valid && !i_ready;
        prev_data  = int'($signed(o_data));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int imp_exp[10] = '{0, -1, 0, 9, 16, 9, 0, -1, 0, 0};
    int imp_in[5]   = '{16, 0, 0, 0, 0};
    int ovf_in[4]   = '{-128, 127, 127, -128};
    bit acc;
    i_reset = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_data  = '0;
    hist    = '{0, 0, 0};
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    @(negedge i_clk);
    chk("init_valid", int'(o_valid), 0);
    chk("init_data", int'($signed(o_data)), 0);
    chk("init_ready", int'(o_ready), 1);

    // Impulse response
    for (int k = 0; k < 5; k++) send(imp_in[k], 1'b0);
    drain();
    chk("imp_count", obs.size(), 10);
    for (int k = 0; k < 10 && k < obs.size(); k++) chk("imp_tap", obs[k], imp_exp[k]);

    // DC gain after fill
    do_reset();
    for (int k = 0; k < 6; k++) send(100, 1'b0);
    drain();
    chk("dc_count", obs.size(), 12);
    for (int k = 6; k < 12 && k < obs.size(); k++) chk("dc_level", obs[k], 100);

    // Overflow of the interpolated sample
    do_reset();
    for (int k = 0; k < 4; k++) send(ovf_in[k], 1'b0);
    drain();
    chk("ovf_count", obs.size(), 8);
`ifdef HS_FIR_INTERP2_SAT_EN
    if (obs.size() == 8) chk("ovf_mid", obs[7], 127);
`else
    if (obs.size() == 8) chk("ovf_mid", obs[7], -97);
`endif

    // Back-pressure in S_OUT0 and S_OUT1 with a pending input
    do_reset();
    send(50, 1'b0);
    repeat (3) step(1'b1, 33, 1'b0, acc);
    step(1'b1, 33, 1'b1, acc);
    repeat (3) step(1'b1, 44, 1'b0, acc);
    step(1'b1, 44, 1'b1, acc);
    chk("bp_accept", int'(acc), 1);
    drain();
    chk("bp_count", obs.size(), 4);

    // Reset while presenting the first output
    do_reset();
    step(1'b1, 77, 1'b0, acc);
    chk("pre_rst_accept", int'(acc), 1);
    do_reset();

    // Continuous streaming
    for (int k = 0; k < 20; k++) send(int'($urandom_range(0, 255)) - 128, 1'b0);
    drain();
    chk("stream_count", obs.size(), 40);

    // Randomized handshakes on both sides
    do_reset();
    for (int k = 0; k < 400; k++)
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
           1'($urandom_range(0, 3) != 0), acc);
    drain();

    chk("final_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
